// File: rtl/serial_rx.sv
// serial_rx: 8N1 oversampling UART receiver with byte strobe, framing error, line-idle and end-of-packet
// Ports: clk, rst_n (async active-low); rxd raw serial input (idle high);
//   data_ready/data received byte strobe and value; framing_error stop-bit-low strobe;
//   idle line high for 10 bit times; endofpacket strobe when idle rises after a good byte.
module serial_rx #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud = 115200,
  parameter int Oversampling = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       data_ready,
  output logic [7:0] data,
  output logic       framing_error,
  output logic       idle,
  output logic       endofpacket
);
  localparam int DIV = (ClkFrequency + Baud * Oversampling / 2) / (Baud * Oversampling);
  localparam int GAP = 10 * Oversampling;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(Oversampling);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  logic [1:0] sync;
  logic rx_s;
  logic [TW-1:0] tcnt;
  logic tick;
  state_t state;
  logic [SW-1:0] sc;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [GW-1:0] gap;
  logic pkt;
  assign rx_s = sync[1];
  assign tick = tcnt == TW'(DIV - 1);
  assign idle = gap == GW'(GAP);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], rxd};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sc <= '0;
      idx <= '0;
      shift <= '0;
      data <= '0;
      data_ready <= 1'b0;
      framing_error <= 1'b0;
      endofpacket <= 1'b0;
      gap <= GW'(GAP);
      pkt <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      framing_error <= 1'b0;
      endofpacket <= 1'b0;
      if (tick) begin
        // only an idle, high line accumulates gap; anything else restarts it
        gap <= (state == IDLE && rx_s) ? (idle ? gap : gap + 1'b1) : '0;
        if (state == IDLE && rx_s && gap == GW'(GAP - 1) && pkt) begin
          endofpacket <= 1'b1;
          pkt <= 1'b0;
        end
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            sc <= '0;
          end
          // mid-start-bit check rejects glitches shorter than half a bit
          START: if (sc == SW'(Oversampling / 2 - 1)) begin
            state <= rx_s ? IDLE : DATA;
            sc <= '0;
            idx <= '0;
          end else sc <= sc + 1'b1;
          DATA: if (&sc) begin
            shift[idx] <= rx_s;
            sc <= '0;
            idx <= idx + 1'b1;
            if (&idx) state <= STOP;
          end else sc <= sc + 1'b1;
          STOP: if (&sc) begin
            sc <= '0;
            if (rx_s) begin
              data <= shift;
              data_ready <= 1'b1;
              pkt <= 1'b1;
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else sc <= sc + 1'b1;
          // a held-low line (break) must return high before a new frame is accepted
          WAIT_HIGH: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
endmodule
